// File: rtl/srl_delay_line.sv
// Addressable WIDTH x DEPTH delay line with run-time tap select, fill tracking,
// flush and a registered copy of the selected tap.
module srl_delay_line #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    a,
  output logic [WIDTH-1:0] y,
  output logic             yv,
  output logic [WIDTH-1:0] q,
  output logic             qv,
  output logic             full
);

  if (WIDTH < 1 || DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("srl_delay_line: WIDTH must be >= 1 and DEPTH a power of two in 2..256");
  end

  localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CntOne  = (AW + 1)'(1);

  logic [WIDTH-1:0] sr [DEPTH];
  logic [AW:0]      cnt_q, cnt_d;
  logic             shift;

  // No reset on the storage so it maps onto shift-register primitives; reset only
  // blocks shifting while asserted.
  assign shift = ce & ~rst;

  always_ff @(posedge clk) begin
    if (shift) begin
      sr[0] <= d;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sr[k] <= sr[k-1];
      end
    end
  end

  // Flush wins over a plain shift, but a sample entering on the same edge counts.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = ce ? CntOne : '0;
    end else if (ce && (cnt_q != CntFull)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign y    = sr[a];
  assign yv   = cnt_q > {1'b0, a};
  assign full = cnt_q == CntFull;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      qv <= 1'b0;
    end else begin
      q  <= y;
      qv <= yv;
    end
  end

endmodule
